pwm_wta_ranker: RTL and testbench
=================================

# pwm_wta_ranker

Parametrised winner-take-all / k-nearest ranking core for the PWM front end. Sits after the per-channel PWM synchronisers and replaces the fixed 8-channel k-NN search. It times each channel's falling edge against a common start, assigns an arrival rank to every channel, and produces nearest and k-nearest masks. Adds configurable tie policy, a measurement timeout, a done strobe and per-channel fall times.

## Interface
Parameters:
- N_CH, 8, number of PWM channels (≥2)
- CNT_W, 12, timer / fall-time width
- RW (derived, not overridable), $clog2(N_CH)+1, rank and k width

Ports:
- clk  in  1  clock; single domain
- rst  in  1  reset; synchronous, active-high
- i_start  in  1  one-cycle pulse; starts or restarts a measurement window
- i_pwm  in  N_CH  synchronised PWM levels, bit i = channel i
- i_k  in  RW  winner count; latched at start
- i_tie_mode  in  1  0 = simultaneous falls share a rank, 1 = lower index wins the tie; latched at start
- i_timeout  in  CNT_W  window length in cycles; latched at start
- o_busy  out  1  high while in RUN
- o_done  out  1  one-cycle pulse when the window closes
- o_valid  out  N_CH  channel fell within the window
- o_nn  out  N_CH  mask of channels with rank 0
- o_knn  out  N_CH  mask of channels with rank < k
- o_rank  out  N_CH*RW  flat; channel i at [(i+1)*RW-1 -: RW]; value N_CH = not fallen
- o_count  out  N_CH*CNT_W  flat; channel i fall time; i_timeout value if not fallen

## Operation
- States: IDLE, RUN, DONE.
- IDLE: results held. i_start moves to RUN.
- On i_start, from any state: latch i_k, i_tie_mode and i_timeout. Clear timer, previous-level register, valid, counts and next_rank. Set all ranks to N_CH.
- RUN:
  - Timer starts at 0 and increments by 1 each cycle.
  - The previous-level register p captures i_pwm every cycle.
  - A fall on channel i occurs when p[i]=1, i_pwm[i]=0 and valid[i]=0. Each channel records at most one fall.
  - On a fall: count[i]=timer, valid[i]=1, and rank[i] is assigned from next_rank.
  - Tie mode 0: every channel falling in the same cycle gets rank = next_rank.
  - Tie mode 1: a falling channel gets next_rank plus the number of lower-index channels falling in the same cycle.
  - In both modes, next_rank += popcount(falls).
- Window close, checked after the current cycle's falls are applied: close when all channels are valid or timer == latched timeout. Go to DONE. Every unfallen channel gets count = latched timeout and keeps rank N_CH.
- DONE: lasts one cycle with o_done=1, then IDLE. An i_start during DONE goes to RUN.
- i_start during RUN aborts the window without a done pulse and restarts it.
- Masks are combinational from the registered state:
  - o_nn[i] = valid[i] & (rank[i]==0)
  - o_knn[i] = valid[i] & (rank[i] < k)
  - k=0 gives empty masks. k ≥ N_CH gives o_knn = o_valid. Tie mode 0 can produce more than k winners.
- Timer never wraps, because the window closes at latched timeout ≤ 2^CNT_W−1.

## Timing
- Reset values: state IDLE, o_busy=0, o_done=0, o_valid=0, o_nn=0, o_knn=0, every rank=N_CH, every count=0.
- Reset mid-window aborts immediately. No o_done is produced.
- i_start sampled at edge t gives o_busy=1 and timer=0 from cycle t+1.
- p is cleared at start, so the earliest possible fall is at timer=1. A channel already low at start must be seen high before a fall is recorded.
- Latency: the low level is sampled in the cycle with timer=T. count=T and rank are visible on the outputs from the next cycle.
- Timeout: with latched timeout = T0 and no early close, o_done is high in the cycle after timer=T0, and o_busy falls in that same cycle.
- The results (o_valid, o_nn, o_knn, o_rank, o_count) are partial during RUN. They are final and stable from the o_done cycle until the next i_start or rst.

## Test plan
- N_CH=8, k=2, mode 0, timeout=100. All channels high, then ch3 falls at timer 3, ch1 at 5, ch6 at 9, and the rest at 12..16 → o_nn=0x08, o_knn=0x0A, rank ch1=1, count ch6=9, o_done within one cycle of the last fall.
- Tie: ch2 and ch5 fall at timer 4, k=1. Mode 0 → o_nn=o_knn=0x24, both ranks 0. Mode 1 → o_nn=o_knn=0x04, rank ch5=1, next fall gets rank 2.
- Timeout=20, only ch0 (t=7) and ch1 (t=11) fall → o_done after the timer=20 cycle, o_valid=0x03, other ranks=8, other counts=20.
- Channel held low from start, never high → never valid. Channel high then low at timer 2 → valid with count=2.
- Restart: i_start at timer 10 with 3 falls recorded → results cleared, no o_done, new window runs to completion normally.
- Reset: rst mid-window → all outputs at reset values, no o_done. k=0 and k=8 → o_knn=0 and o_knn=o_valid respectively.

Source files
------------

// File: rtl/pwm_wta_ranker.sv
`default_nettype none
// ============================================================================
// Module      : pwm_wta_ranker
// Description : Times falling edges of N_CH PWM channels against a common
//               start and ranks them by arrival (winner-take-all / k-NN masks).
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_wta_ranker #(
    parameter  int N_CH  = 8,
    parameter  int CNT_W = 12,
    localparam int RW    = $clog2(N_CH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [N_CH-1:0]       i_pwm,
    input  logic [RW-1:0]         i_k,
    input  logic                  i_tie_mode,
    input  logic [CNT_W-1:0]      i_timeout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N_CH-1:0]       o_valid,
    output logic [N_CH-1:0]       o_nn,
    output logic [N_CH-1:0]       o_knn,
    output logic [N_CH*RW-1:0]    o_rank,
    output logic [N_CH*CNT_W-1:0] o_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] c_NOT_FALLEN = RW'(N_CH);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_timeout;
    logic [RW-1:0]    r_k;
    logic             r_tie_mode;
    logic [N_CH-1:0]  r_p;
    logic [N_CH-1:0]  r_valid;
    logic [RW-1:0]    r_next_rank;
    logic [CNT_W-1:0] r_count [N_CH];
    logic [RW-1:0]    r_rank  [N_CH];

    logic [N_CH-1:0]  w_fall;
    logic [RW-1:0]    w_fall_cnt;
    logic [RW-1:0]    w_new_rank [N_CH];
    logic             w_close;

    // Running popcount: in tie mode 1 each faller is offset by the number of
    // lower-index channels falling in the same cycle.
    always_comb begin
        w_fall     = r_p & ~i_pwm & ~r_valid;
        w_fall_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_new_rank[i] = r_tie_mode ? (r_next_rank + w_fall_cnt) : r_next_rank;
            w_fall_cnt    = w_fall_cnt + RW'(w_fall[i]);
        end
        w_close = (&(r_valid | w_fall)) || (r_timer == r_timeout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_next = ST_RUN;
            ST_RUN: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                end else if (w_close) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = i_start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_timeout   <= '0;
            r_k         <= '0;
            r_tie_mode  <= 1'b0;
            r_p         <= '0;
            r_valid     <= '0;
            r_next_rank <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_count[i] <= '0;
                r_rank[i]  <= c_NOT_FALLEN;
            end
        end else if (i_start) begin
            r_timer     <= '0;
            r_timeout   <= i_timeout;
            r_k         <= i_k;
            r_tie_mode  <= i_tie_mode;
            r_p         <= '0;
            r_valid     <= '0;
            r_next_rank <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_count[i] <= '0;
                r_rank[i]  <= c_NOT_FALLEN;
            end
        end else if (r_state == ST_RUN) begin
            // Holding the timer on close keeps it from wrapping at the maximum timeout.
            if (!w_close) begin
                r_timer <= r_timer + CNT_W'(1);
            end
            r_p         <= i_pwm;
            r_valid     <= r_valid | w_fall;
            r_next_rank <= r_next_rank + w_fall_cnt;
            for (int i = 0; i < N_CH; i++) begin
                if (w_fall[i]) begin
                    r_count[i] <= r_timer;
                    r_rank[i]  <= w_new_rank[i];
                end else if (w_close && !r_valid[i]) begin
                    r_count[i] <= r_timeout;
                end
            end
        end
    end

    assign o_busy  = (r_state == ST_RUN);
    assign o_done  = (r_state == ST_DONE);
    assign o_valid = r_valid;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
        assign o_rank[(gi+1)*RW-1 -: RW]       = r_rank[gi];
        assign o_count[(gi+1)*CNT_W-1 -: CNT_W] = r_count[gi];
        assign o_nn[gi]  = r_valid[gi] & (r_rank[gi] == '0);
        assign o_knn[gi] = r_valid[gi] & (r_rank[gi] < r_k);
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_wta_ranker.sv
`default_nettype none
// Testbench for pwm_wta_ranker: directed and randomized windows checked
// against an arrival-time ranking model built from per-cycle level tables.
module tb_pwm_wta_ranker;
    localparam int N_CH  = 8;
    localparam int CNT_W = 12;
    localparam int RW    = 4;
    localparam int MAXT  = 256;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_start;
    logic [N_CH-1:0]       i_pwm;
    logic [RW-1:0]         i_k;
    logic                  i_tie_mode;
    logic [CNT_W-1:0]      i_timeout;
    logic                  o_busy;
    logic                  o_done;
    logic [N_CH-1:0]       o_valid;
    logic [N_CH-1:0]       o_nn;
    logic [N_CH-1:0]       o_knn;
    logic [N_CH*RW-1:0]    o_rank;
    logic [N_CH*CNT_W-1:0] o_count;

    always #5 clk = ~clk;

    pwm_wta_ranker #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pwm(i_pwm), .i_k(i_k),
        .i_tie_mode(i_tie_mode), .i_timeout(i_timeout), .o_busy(o_busy),
        .o_done(o_done), .o_valid(o_valid), .o_nn(o_nn), .o_knn(o_knn),
        .o_rank(o_rank), .o_count(o_count)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit lv [N_CH][MAXT];
    int tmo;
    bit mode;
    int kk;

    logic [N_CH*RW-1:0]    all_unranked;
    logic [N_CH-1:0]       ev, en, ek;
    logic [N_CH*RW-1:0]    er;
    logic [N_CH*CNT_W-1:0] ec;
    int                    eclose;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_never(input int ch);
        for (int t = 0; t < MAXT; t++) lv[ch][t] = 1'b1;
    endtask

    task automatic set_low(input int ch);
        for (int t = 0; t < MAXT; t++) lv[ch][t] = 1'b0;
    endtask

    task automatic set_fall(input int ch, input int f, input bit noisy);
        for (int t = 0; t < MAXT; t++)
            lv[ch][t] = (t < f) ? 1'b1 : (t == f) ? 1'b0 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic set_rand(input int ch);
        for (int t = 0; t < MAXT; t++) lv[ch][t] = 1'($urandom_range(0, 1));
    endtask

    // Arrival model: first high->low transition (timer >= 1) is the fall time;
    // rank = number of channels that arrived strictly earlier (plus lower-index
    // simultaneous arrivals when ties are broken by index).
    task automatic model();
        int ff [N_CH];
        bit all_fell;
        int mx;
        int r;
        all_fell = 1'b1;
        mx = 0;
        for (int i = 0; i < N_CH; i++) begin
            ff[i] = -1;
            for (int t = 1; t <= tmo; t++)
                if (ff[i] < 0 && lv[i][t-1] && !lv[i][t]) ff[i] = t;
            if (ff[i] < 0) all_fell = 1'b0;
            else if (ff[i] > mx) mx = ff[i];
        end
        eclose = all_fell ? mx : tmo;
        for (int i = 0; i < N_CH; i++) begin
            r = N_CH;
            if (ff[i] >= 0) begin
                r = 0;
                for (int j = 0; j < N_CH; j++)
                    if (ff[j] >= 0 && (ff[j] < ff[i] || (mode && ff[j] == ff[i] && j < i))) r++;
            end
            ev[i] = (ff[i] >= 0);
            en[i] = ev[i] && (r == 0);
            ek[i] = ev[i] && (r < kk);
            er[i*RW +: RW] = RW'(r);
            ec[i*CNT_W +: CNT_W] = ev[i] ? CNT_W'(ff[i]) : CNT_W'(tmo);
        end
    endtask

    task automatic drive_level(input int t);
        for (int i = 0; i < N_CH; i++) i_pwm[i] = (t < MAXT) ? lv[i][t] : 1'b1;
    endtask

    task automatic start_window(input string tag, input int t, input bit m, input int k);
        tmo = t;
        mode = m;
        kk = k;
        i_timeout = CNT_W'(t);
        i_tie_mode = m;
        i_k = RW'(k);
        i_start = 1'b1;
        i_pwm = 8'($urandom);
        tick();
        i_start = 1'b0;
        // Scramble the latched controls to show they are held internally.
        i_timeout = CNT_W'($urandom);
        i_tie_mode = 1'($urandom);
        i_k = RW'($urandom);
        check({tag, " busy@start"}, 128'(o_busy), 128'(1));
        check({tag, " valid@start"}, 128'(o_valid), 128'(0));
    endtask

    task automatic run_cycles(input int t0, input int n, output bit saw_done);
        saw_done = 1'b0;
        for (int t = t0; t < t0 + n; t++) begin
            drive_level(t);
            tick();
            if (o_done) saw_done = 1'b1;
        end
    endtask

    task automatic run_window(input string tag);
        int done_at;
        model();
        done_at = -1;
        for (int t = 0; t <= tmo + 3 && done_at < 0; t++) begin
            drive_level(t);
            tick();
            if (o_done === 1'b1) done_at = t;
        end
        check({tag, " done_time"}, 128'(done_at), 128'(eclose));
        check({tag, " busy@done"}, 128'(o_busy), 128'(0));
        check({tag, " valid"}, 128'(o_valid), 128'(ev));
        check({tag, " nn"}, 128'(o_nn), 128'(en));
        check({tag, " knn"}, 128'(o_knn), 128'(ek));
        check({tag, " rank"}, 128'(o_rank), 128'(er));
        check({tag, " count"}, 128'(o_count), 128'(ec));
        i_pwm = 8'($urandom);
        tick();
        check({tag, " done_pulse"}, 128'(o_done), 128'(0));
        check({tag, " rank_hold"}, 128'(o_rank), 128'(er));
        check({tag, " count_hold"}, 128'(o_count), 128'(ec));
    endtask

    initial begin
        bit saw;
        int ct;
        for (int i = 0; i < N_CH; i++) all_unranked[i*RW +: RW] = RW'(N_CH);
        rst = 1'b1; i_start = 1'b0; i_pwm = '0; i_k = '0; i_tie_mode = 1'b0; i_timeout = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", 128'(o_busy), 128'(0));
        check("reset done", 128'(o_done), 128'(0));
        check("reset valid", 128'(o_valid), 128'(0));
        check("reset nn", 128'(o_nn), 128'(0));
        check("reset knn", 128'(o_knn), 128'(0));
        check("reset rank", 128'(o_rank), 128'(all_unranked));
        check("reset count", 128'(o_count), 128'(0));

        // Basic ordering: ch3@3, ch1@5, ch6@9, rest 12..16.
        set_fall(3, 3, 0); set_fall(1, 5, 0); set_fall(6, 9, 0);
        set_fall(0, 12, 0); set_fall(2, 13, 0); set_fall(4, 14, 0);
        set_fall(5, 15, 0); set_fall(7, 16, 0);
        start_window("basic", 100, 0, 2);
        run_window("basic");
        check("basic nn_const", 128'(o_nn), 128'(8'h08));
        check("basic knn_const", 128'(o_knn), 128'(8'h0A));
        check("basic rank1", 128'(o_rank[1*RW +: RW]), 128'(1));
        check("basic count6", 128'(o_count[6*CNT_W +: CNT_W]), 128'(9));

        // Tie between ch2 and ch5, next faller ch7.
        for (int i = 0; i < N_CH; i++) set_never(i);
        set_fall(2, 4, 0); set_fall(5, 4, 0); set_fall(7, 8, 0);
        start_window("tie0", 30, 0, 1);
        run_window("tie0");
        check("tie0 nn_const", 128'(o_nn), 128'(8'h24));
        check("tie0 rank7", 128'(o_rank[7*RW +: RW]), 128'(2));
        start_window("tie1", 30, 1, 1);
        run_window("tie1");
        check("tie1 knn_const", 128'(o_knn), 128'(8'h04));
        check("tie1 rank5", 128'(o_rank[5*RW +: RW]), 128'(1));
        check("tie1 rank7", 128'(o_rank[7*RW +: RW]), 128'(2));

        // Timeout with partial arrivals.
        for (int i = 0; i < N_CH; i++) set_never(i);
        set_fall(0, 7, 1); set_fall(1, 11, 1);
        start_window("tmo", 20, 0, 3);
        run_window("tmo");
        check("tmo valid_const", 128'(o_valid), 128'(8'h03));
        check("tmo count7", 128'(o_count[7*CNT_W +: CNT_W]), 128'(20));

        // Held low from start, early fall at 2, and low-high-low.
        for (int i = 0; i < N_CH; i++) set_never(i);
        set_low(4); set_fall(5, 2, 0);
        for (int t = 0; t < MAXT; t++) lv[6][t] = (t >= 2 && t < 5);
        start_window("low", 15, 1, 8);
        run_window("low");
        check("low valid4", 128'(o_valid[4]), 128'(0));
        check("low count5", 128'(o_count[5*CNT_W +: CNT_W]), 128'(2));

        // Restart at timer 10 with three falls recorded.
        for (int i = 0; i < N_CH; i++) set_never(i);
        set_fall(0, 2, 0); set_fall(1, 4, 0); set_fall(2, 6, 0);
        start_window("pre", 100, 0, 2);
        run_cycles(0, 10, saw);
        check("restart partial", 128'(o_valid), 128'(8'h07));
        for (int i = 0; i < N_CH; i++) set_fall(i, 3 + i, 0);
        start_window("restart", 50, 1, 4);
        check("restart done", 128'({saw, o_done}), 128'(0));
        check("restart rank", 128'(o_rank), 128'(all_unranked));
        check("restart count", 128'(o_count), 128'(0));
        run_window("restart");

        // Reset mid-window.
        for (int i = 0; i < N_CH; i++) set_never(i);
        set_fall(0, 2, 0);
        start_window("rstwin", 40, 0, 2);
        run_cycles(0, 8, saw);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", 128'(o_busy), 128'(0));
        check("midrst valid", 128'(o_valid), 128'(0));
        check("midrst rank", 128'(o_rank), 128'(all_unranked));
        check("midrst count", 128'(o_count), 128'(0));
        run_cycles(8, 5, saw);
        check("midrst nodone", 128'({saw, o_busy}), 128'(0));

        // k boundaries.
        for (int i = 0; i < N_CH; i++) set_fall(i, 1 + $urandom_range(0, 12), 1);
        start_window("k0", 40, 0, 0);
        run_window("k0");
        check("k0 knn_const", 128'(o_knn), 128'(0));
        start_window("k8", 40, 1, 8);
        run_window("k8");
        check("k8 knn_all", 128'(o_knn), 128'(8'hFF));

        // Randomized windows.
        for (int w = 0; w < 30; w++) begin
            int t0;
            t0 = $urandom_range(0, 60);
            ct = $urandom_range(1, t0 + 2);
            for (int i = 0; i < N_CH; i++) begin
                case ($urandom_range(0, 5))
                    0, 1: set_fall(i, $urandom_range(1, t0 + 5), 1'($urandom_range(0, 1)));
                    2: set_never(i);
                    3: set_low(i);
                    4: set_rand(i);
                    default: set_fall(i, ct, 0);
                endcase
            end
            start_window("rand", t0, 1'($urandom_range(0, 1)), $urandom_range(0, 8));
            run_window("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
